// File: rtl/sniff_fifo_drain_pkg.sv
// Shared definitions for the sniff FIFO drain sequencer: state encodings and the
// byte layout of one FIFO entry on the USB stream.
package sniff_fifo_drain_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FLUSH = 3'd1,
      ST_FETCH = 3'd2,
      ST_LOAD  = 3'd3,
      ST_SEND  = 3'd4,
      ST_DONE  = 3'd5
   } drain_state_e;

   localparam int B0_LSB      = 0;
   localparam int B1_LSB      = 8;
   localparam int B2_DOUT_LSB = 16;
   localparam logic [1:0] BYTE_LAST = 2'd2;

   // b0 = dout[7:0], b1 = dout[15:8], b2 = {status, dout[17:16]}
   function automatic logic [7:0] pick_byte(input logic [1:0]  idx,
                                            input logic [17:0] dout,
                                            input logic [5:0]  stat);
      logic [7:0] b;
      case (idx)
         2'd0:    b = dout[B0_LSB +: 8];
         2'd1:    b = dout[B1_LSB +: 8];
         default: b = {stat, dout[B2_DOUT_LSB +: 2]};
      endcase
      return b;
   endfunction

endpackage

// File: rtl/sniff_fifo_drain.sv
// Read-side sequencer for the sniff FIFO: flush-on-arm, then burst unload of
// entries as a 3-byte-per-entry stream toward the USB bulk endpoint.
//
// state | meaning
// IDLE  | waiting for an arm edge (or pending arm) or a start pulse
// FLUSH | draining the FIFO before arming the front end
// FETCH | issuing one read strobe, or counting empty cycles toward timeout
// LOAD  | capturing read data and status into the holding register
// SEND  | serializing the 3 bytes of the held entry
// DONE  | one-cycle end-of-burst pulse
module sniff_fifo_drain
   import sniff_fifo_drain_pkg::*;
#(
   parameter int pFIFO_WIDTH    = 18,
   parameter int pSTAT_WIDTH    = 6,
   parameter int pTIMEOUT_WIDTH = 10
) (
   input  logic                   cwusb_clk,
   input  logic                   reset_n,
   input  logic                   arm_req_i,
   input  logic                   start_i,
   input  logic [15:0]            burst_len_i,
   input  logic                   fifo_empty_i,
   input  logic [pFIFO_WIDTH-1:0] fifo_dout_i,
   input  logic [pSTAT_WIDTH-1:0] fifo_status_i,
   output logic                   fifo_rd_en_o,
   output logic [7:0]             m_data_o,
   output logic                   m_valid_o,
   input  logic                   m_ready_i,
   output logic                   arm_o,
   output logic                   flushing_o,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   timed_out_o,
   output logic [15:0]            entries_sent_o
);

   localparam logic [pTIMEOUT_WIDTH-1:0] TMO_LOAD = '1;
   localparam logic [pTIMEOUT_WIDTH-1:0] TMO_LAST = pTIMEOUT_WIDTH'(1);

   drain_state_e              state_q, state_d;
   logic                      arm_req_q, arm_req_d;
   logic                      arm_pend_q, arm_pend_d;
   logic                      arm_q, arm_d;
   logic                      timed_out_q, timed_out_d;
   logic [15:0]               remaining_q, remaining_d;
   logic [15:0]               entries_q, entries_d;
   logic [pTIMEOUT_WIDTH-1:0] tmo_q, tmo_d;
   logic [1:0]                idx_q, idx_d;
   logic [pFIFO_WIDTH-1:0]    dout_hold_q, dout_hold_d;
   logic [pSTAT_WIDTH-1:0]    stat_hold_q, stat_hold_d;
   logic                      arm_edge;

   always_ff @(posedge cwusb_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         arm_req_q   <= 1'b0;
         arm_pend_q  <= 1'b0;
         arm_q       <= 1'b0;
         timed_out_q <= 1'b0;
         remaining_q <= '0;
         entries_q   <= '0;
         tmo_q       <= TMO_LOAD;
         idx_q       <= '0;
         dout_hold_q <= '0;
         stat_hold_q <= '0;
      end else begin
         state_q     <= state_d;
         arm_req_q   <= arm_req_d;
         arm_pend_q  <= arm_pend_d;
         arm_q       <= arm_d;
         timed_out_q <= timed_out_d;
         remaining_q <= remaining_d;
         entries_q   <= entries_d;
         tmo_q       <= tmo_d;
         idx_q       <= idx_d;
         dout_hold_q <= dout_hold_d;
         stat_hold_q <= stat_hold_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      arm_req_d    = arm_req_i;
      arm_pend_d   = arm_pend_q;
      arm_d        = arm_q;
      timed_out_d  = timed_out_q;
      remaining_d  = remaining_q;
      entries_d    = entries_q;
      tmo_d        = tmo_q;
      idx_d        = idx_q;
      dout_hold_d  = dout_hold_q;
      stat_hold_d  = stat_hold_q;
      fifo_rd_en_o = 1'b0;
      m_data_o     = 8'h00;
      m_valid_o    = 1'b0;
      flushing_o   = 1'b0;
      done_o       = 1'b0;

      arm_edge = arm_req_i & ~arm_req_q;
      if (!arm_req_i)
         arm_d = 1'b0;
      if (arm_edge && state_q != ST_IDLE)
         arm_pend_d = 1'b1;

      case (state_q)
         ST_IDLE: begin
            if (arm_edge || arm_pend_q) begin
               // arm_o must already be low on the first flushing cycle
               state_d    = ST_FLUSH;
               arm_pend_d = 1'b0;
               arm_d      = 1'b0;
            end else if (start_i) begin
               remaining_d = burst_len_i;
               entries_d   = '0;
               timed_out_d = 1'b0;
               tmo_d       = TMO_LOAD;
               state_d     = (burst_len_i == 16'd0) ? ST_DONE : ST_FETCH;
            end
         end
         ST_FLUSH: begin
            flushing_o   = 1'b1;
            fifo_rd_en_o = ~fifo_empty_i;
            if (fifo_empty_i) begin
               arm_d   = arm_req_i;
               state_d = ST_IDLE;
            end
         end
         ST_FETCH: begin
            if (!fifo_empty_i) begin
               fifo_rd_en_o = 1'b1;
               tmo_d        = TMO_LOAD;
               state_d      = ST_LOAD;
            end else if (tmo_q == TMO_LAST) begin
               timed_out_d = 1'b1;
               state_d     = ST_DONE;
            end else begin
               tmo_d = tmo_q - TMO_LAST;
            end
         end
         ST_LOAD: begin
            dout_hold_d = fifo_dout_i;
            stat_hold_d = fifo_status_i;
            idx_d       = '0;
            state_d     = ST_SEND;
         end
         ST_SEND: begin
            m_valid_o = 1'b1;
            m_data_o  = pick_byte(idx_q, dout_hold_q, stat_hold_q);
            if (m_ready_i) begin
               if (idx_q == BYTE_LAST) begin
                  entries_d   = (entries_q == 16'hFFFF) ? entries_q : entries_q + 16'd1;
                  remaining_d = remaining_q - 16'd1;
                  state_d     = (remaining_q == 16'd1) ? ST_DONE : ST_FETCH;
               end else begin
                  idx_d = idx_q + 2'd1;
               end
            end
         end
         ST_DONE: begin
            done_o  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign busy_o         = (state_q != ST_IDLE);
   assign arm_o          = arm_q;
   assign timed_out_o    = timed_out_q;
   assign entries_sent_o = entries_q;

endmodule

// File: tb/tb_sniff_fifo_drain.sv
// Bench for sniff_fifo_drain: FIFO model, expected-byte scoreboard with a
// decoupled stream monitor, and directed flush/burst/timeout/reset scenarios.
module tb_sniff_fifo_drain;

   logic        cwusb_clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        arm_req_i = 1'b0;
   logic        start_i = 1'b0;
   logic [15:0] burst_len_i = 16'd0;
   logic        fifo_empty_i;
   logic [17:0] fifo_dout_i = 18'd0;
   logic [5:0]  fifo_status_i = 6'd0;
   logic        fifo_rd_en_o;
   logic [7:0]  m_data_o;
   logic        m_valid_o;
   logic        m_ready_i = 1'b1;
   logic        arm_o, flushing_o, busy_o, done_o, timed_out_o;
   logic [15:0] entries_sent_o;

   sniff_fifo_drain #(.pFIFO_WIDTH(18), .pSTAT_WIDTH(6), .pTIMEOUT_WIDTH(4)) dut (
      .cwusb_clk     (cwusb_clk),
      .reset_n       (reset_n),
      .arm_req_i     (arm_req_i),
      .start_i       (start_i),
      .burst_len_i   (burst_len_i),
      .fifo_empty_i  (fifo_empty_i),
      .fifo_dout_i   (fifo_dout_i),
      .fifo_status_i (fifo_status_i),
      .fifo_rd_en_o  (fifo_rd_en_o),
      .m_data_o      (m_data_o),
      .m_valid_o     (m_valid_o),
      .m_ready_i     (m_ready_i),
      .arm_o         (arm_o),
      .flushing_o    (flushing_o),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .timed_out_o   (timed_out_o),
      .entries_sent_o(entries_sent_o)
   );

   always #5 cwusb_clk = ~cwusb_clk;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   always @(posedge cwusb_clk) cyc++;

   // FIFO model: stimulus writes, read strobe pops with one-cycle read latency
   logic [17:0] mem [0:63];
   int wr_ptr = 0;
   int rd_ptr = 0;
   assign fifo_empty_i = (wr_ptr == rd_ptr);
   always @(posedge cwusb_clk) begin
      if (fifo_rd_en_o && (wr_ptr != rd_ptr)) begin
         fifo_dout_i <= mem[rd_ptr];
         rd_ptr      <= rd_ptr + 1;
      end
   end

   int ready_mode = 0;
   initial begin
      forever begin
         @(posedge cwusb_clk);
         #1;
         case (ready_mode)
            1:       m_ready_i = ((cyc % 3) == 0);
            2:       m_ready_i = 1'b0;
            default: m_ready_i = 1'b1;
         endcase
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // scoreboard and monitor
   logic [7:0] exp_q[$];
   int acc_cyc[$];
   int done_cnt = 0, done_cyc = 0;
   int rd_cnt = 0, underflow = 0, arm_flush_overlap = 0;
   int flush_cnt = 0, last_flush_cyc = 0, arm_rise_cyc = 0;
   logic arm_prev = 1'b0;
   logic hold_pend = 1'b0;
   logic [7:0] hold_data = 8'h00;

   always @(negedge cwusb_clk) begin
      if (!reset_n) begin
         hold_pend = 1'b0;
         arm_prev  = 1'b0;
      end else begin
         if (hold_pend)
            chk("data_stable", {23'd0, m_valid_o, m_data_o}, {23'd0, 1'b1, hold_data});
         hold_pend = 1'b0;
         if (m_valid_o && m_ready_i) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_byte: got %0h expected none (cycle %0d)", m_data_o, cyc);
            end else begin
               chk("stream_byte", {24'd0, m_data_o}, {24'd0, exp_q.pop_front()});
            end
            acc_cyc.push_back(cyc);
         end else if (m_valid_o) begin
            hold_pend = 1'b1;
            hold_data = m_data_o;
         end
         if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (fifo_rd_en_o) rd_cnt++;
         if (fifo_rd_en_o && fifo_empty_i) underflow++;
         if (arm_o && flushing_o) arm_flush_overlap++;
         if (flushing_o) begin
            flush_cnt++;
            last_flush_cyc = cyc;
         end
         if (arm_o && !arm_prev) arm_rise_cyc = cyc;
         arm_prev = arm_o;
      end
   end

   task automatic tick();
      @(negedge cwusb_clk);
      #1;
   endtask

   task automatic push_entry(input logic [17:0] d);
      mem[wr_ptr] = d;
      wr_ptr++;
   endtask

   task automatic expect_entry(input logic [17:0] d);
      exp_q.push_back(d[7:0]);
      exp_q.push_back(d[15:8]);
      exp_q.push_back({fifo_status_i, d[17:16]});
   endtask

   task automatic start_burst(input logic [15:0] len, output int s);
      burst_len_i = len;
      start_i     = 1'b1;
      s           = cyc;
      tick();
      start_i     = 1'b0;
   endtask

   task automatic wait_done(input int base, input int max, input string nm);
      int n = 0;
      while (done_cnt == base && n < max) begin
         tick();
         n++;
      end
      if (done_cnt == base) begin
         n_vec++;
         n_err++;
         $display("FAIL %s: done_o not seen within %0d cycles", nm, max);
      end
   endtask

   task automatic wait_arm(input int max, input string nm);
      int n = 0;
      while (!arm_o && n < max) begin
         tick();
         n++;
      end
      if (!arm_o) begin
         n_vec++;
         n_err++;
         $display("FAIL %s: arm_o not seen within %0d cycles", nm, max);
      end
   endtask

   function automatic logic [31:0] all_outs();
      return {1'b0, fifo_rd_en_o, m_data_o, m_valid_o, arm_o, flushing_o, busy_o,
              done_o, timed_out_o, entries_sent_o};
   endfunction

   initial begin
      int s, d0, r0, a0, f0;
      repeat (3) tick();
      chk("reset_outputs", all_outs(), 32'd0);
      reset_n = 1'b1;
      tick();
      chk("idle_outputs", all_outs(), 32'd0);

      // flush of 3 entries on arm edge
      push_entry(18'h0_0001); push_entry(18'h0_0002); push_entry(18'h0_0003);
      tick(); tick();
      r0 = rd_cnt;
      arm_req_i = 1'b1;
      wait_arm(30, "flush_arm");
      chk("flush_rd_count", rd_cnt - r0, 3);
      chk("flush_fifo_empty", {31'd0, fifo_empty_i}, 1);
      chk("arm_one_after_flush", arm_rise_cyc - last_flush_cyc, 1);
      chk("arm_during_flush", arm_flush_overlap, 0);
      arm_req_i = 1'b0;
      tick(); tick();
      chk("arm_clears", {31'd0, arm_o}, 0);

      // 4-entry burst, ready held high
      fifo_status_i = 6'h2B;
      for (int i = 0; i < 4; i++) begin
         push_entry(18'h2_A55A);
         expect_entry(18'h2_A55A);
      end
      tick();
      d0 = done_cnt; a0 = acc_cyc.size(); r0 = rd_cnt;
      start_burst(16'd4, s);
      wait_done(d0, 100, "burst4_done");
      repeat (3) tick();
      chk("burst4_bytes", acc_cyc.size() - a0, 12);
      chk("burst4_first_byte", acc_cyc[a0] - s, 3);
      chk("burst4_entry_rate", acc_cyc[a0 + 3] - acc_cyc[a0], 5);
      chk("burst4_last_byte", acc_cyc[a0 + 11] - s, 20);
      chk("burst4_done_cycle", done_cyc - s, 21);
      chk("burst4_done_once", done_cnt - d0, 1);
      chk("burst4_entries", entries_sent_o, 4);
      chk("burst4_rd_count", rd_cnt - r0, 4);

      // same burst, ready 1-of-3
      for (int i = 0; i < 4; i++) begin
         push_entry(18'h2_A55A);
         expect_entry(18'h2_A55A);
      end
      ready_mode = 1;
      tick();
      d0 = done_cnt; a0 = acc_cyc.size();
      start_burst(16'd4, s);
      wait_done(d0, 200, "burst4_bp_done");
      repeat (3) tick();
      ready_mode = 0;
      chk("burst4_bp_bytes", acc_cyc.size() - a0, 12);
      chk("burst4_bp_done_once", done_cnt - d0, 1);
      chk("burst4_bp_entries", entries_sent_o, 4);

      // timeout: 5 requested, 2 available
      fifo_status_i = 6'h15;
      push_entry(18'h1_1234); expect_entry(18'h1_1234);
      push_entry(18'h3_BEEF); expect_entry(18'h3_BEEF);
      tick();
      d0 = done_cnt; a0 = acc_cyc.size(); r0 = rd_cnt;
      start_burst(16'd5, s);
      wait_done(d0, 100, "timeout_done");
      repeat (2) tick();
      chk("timeout_bytes", acc_cyc.size() - a0, 6);
      chk("timeout_flag", {31'd0, timed_out_o}, 1);
      chk("timeout_entries", entries_sent_o, 2);
      chk("timeout_wait", done_cyc - acc_cyc[a0 + 5], 16);
      chk("timeout_rd_count", rd_cnt - r0, 2);
      chk("no_underflow", underflow, 0);

      // arm edge mid-burst: burst unchanged, flush afterwards
      fifo_status_i = 6'h3C;
      push_entry(18'h1_C3F0); expect_entry(18'h1_C3F0);
      push_entry(18'h0_5A01); expect_entry(18'h0_5A01);
      push_entry(18'h3_FFFF);
      tick();
      d0 = done_cnt; a0 = acc_cyc.size(); r0 = rd_cnt; f0 = flush_cnt;
      start_burst(16'd2, s);
      tick();
      chk("start_clears_timeout", {31'd0, timed_out_o}, 0);
      repeat (4) tick();
      arm_req_i = 1'b1;
      wait_done(d0, 100, "midarm_done");
      chk("midarm_no_flush_yet", flush_cnt - f0, 0);
      wait_arm(30, "midarm_arm");
      chk("midarm_bytes", acc_cyc.size() - a0, 6);
      chk("midarm_entries", entries_sent_o, 2);
      chk("midarm_rd_count", rd_cnt - r0, 3);
      chk("midarm_flushed", {31'd0, fifo_empty_i}, 1);

      // arm edge with start in the same cycle: flush only
      arm_req_i = 1'b0;
      repeat (2) tick();
      push_entry(18'h2_0001);
      repeat (2) tick();
      d0 = done_cnt; a0 = acc_cyc.size(); r0 = rd_cnt; f0 = flush_cnt;
      arm_req_i = 1'b1;
      start_burst(16'd1, s);
      repeat (20) tick();
      chk("armstart_no_done", done_cnt - d0, 0);
      chk("armstart_no_bytes", acc_cyc.size() - a0, 0);
      chk("armstart_flush_rd", rd_cnt - r0, 1);
      chk("armstart_entries", entries_sent_o, 2);
      chk("armstart_armed", {31'd0, arm_o}, 1);

      // reset mid-SEND, then zero-length burst
      arm_req_i = 1'b0;
      repeat (2) tick();
      push_entry(18'h0_1111); push_entry(18'h0_2222);
      ready_mode = 2;
      tick(); tick();
      start_burst(16'd2, s);
      for (int n = 0; n < 10 && !m_valid_o; n++) tick();
      chk("reset_pre_valid", {31'd0, m_valid_o}, 1);
      @(negedge cwusb_clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk("reset_async_outputs", all_outs(), 32'd0);
      tick(); tick();
      ready_mode = 0;
      reset_n = 1'b1;
      tick();
      chk("post_reset_outputs", all_outs(), 32'd0);
      d0 = done_cnt; a0 = acc_cyc.size();
      start_burst(16'd0, s);
      wait_done(d0, 10, "zero_len_done");
      repeat (3) tick();
      chk("zero_len_done_cycle", done_cyc - s, 1);
      chk("zero_len_done_once", done_cnt - d0, 1);
      chk("zero_len_no_bytes", acc_cyc.size() - a0, 0);
      chk("zero_len_entries", entries_sent_o, 0);
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
